ifetch_bridge: RTL and testbench
================================

# ifetch_bridge

Instruction-fetch bridge between the PC register and the instruction-side SRAM-like bus. It accepts the fetch address and fetch enable from the PC stage and maps the virtual PC to a physical address. It runs one bus transaction at a time and delivers the returned word to decode through a one-entry output buffer. It back-pressures the PC through `fetch_ready` and discards in-flight responses on pipeline flush.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, instruction width
- `clk` in 1, clock
- `rst` in 1, reset, synchronous, active-high
- `fetch_en` in 1, PC stage holds a valid fetch address (PC chip-enable)
- `fetch_pc` in ADDR_W, virtual fetch address
- `fetch_ready` out 1, PC may load its next value this edge (combinational)
- `flush` in 1, redirect: abandon current fetch
- `de_stall` in 1, decode cannot accept an instruction this cycle
- `inst_valid` out 1, `inst`/`inst_pc` valid for decode
- `inst` out DATA_W, fetched instruction
- `inst_pc` out ADDR_W, virtual PC of `inst`
- `inst_adel` out 1, address-error (misaligned fetch) flag with `inst_valid`
- `inst_req` out 1, bus request
- `inst_addr` out ADDR_W, physical bus address
- `inst_addr_ok` in 1, bus accepted address
- `inst_data_ok` in 1, bus returns data
- `inst_rdata` in DATA_W, bus read data

## Operation
- States: IDLE, REQ, RESP, HOLD. There is also a `cancel` flag register.
- IDLE:
  - On `fetch_en` with `fetch_pc[1:0]==0`, latch `fetch_pc` into `inst_pc` and the mapped address into `inst_addr`, then go to REQ.
  - On `fetch_en` with `fetch_pc[1:0]!=0`, latch `inst_pc`, set `inst`=0 and `inst_adel`=1, then go to HOLD. No bus request is issued.
- Address map:
  - If `fetch_pc[31:30]==2'b10` (kseg0/kseg1), `inst_addr` = {3'b000, `fetch_pc[28:0]`}.
  - Otherwise `inst_addr` = `fetch_pc`.
  - Example: 0xbfc00000 maps to 0x1fc00000.
- REQ:
  - `inst_req`=1.
  - `inst_addr` is held stable until `inst_addr_ok`, then go to RESP.
  - The request is never withdrawn before `inst_addr_ok`, even on `flush`.
- RESP:
  - Wait for `inst_data_ok`.
  - If `cancel`=0, capture `inst_rdata` into `inst`, clear `inst_adel`, and go to HOLD.
  - If `cancel`=1, drop the data, clear `cancel`, and go to IDLE.
- HOLD:
  - `inst_valid`=1.
  - If `!de_stall`, the instruction is delivered: `fetch_ready`=1, go to IDLE.
  - Otherwise hold all outputs stable.
- `fetch_ready` = (HOLD & !`de_stall`) | `flush`.
- `flush`:
  - In IDLE: no effect beyond `fetch_ready`.
  - In REQ or RESP: set `cancel`. The transaction completes on the bus and its data is discarded. `inst_data_ok` arriving in the same cycle as `flush` is also discarded.
  - In HOLD: drop the buffer, `inst_valid` falls next cycle, go to IDLE.
- Single outstanding transaction only. `inst_data_ok` outside RESP is ignored.
- `inst_pc`, `inst`, `inst_adel` change only on IDLE→REQ/HOLD and on RESP→HOLD.

## Timing
- Reset values:
  - state IDLE, `cancel` 0
  - `inst_req` 0, `inst_addr` 0
  - `inst_valid` 0, `inst` 0, `inst_pc` 0, `inst_adel` 0
  - `fetch_ready` 0 (unless `flush`)
- Reset mid-transaction returns to IDLE immediately. The bus slave is reset by the same `rst`.
- Zero-wait bus (`addr_ok` in the same cycle as `req`, `data_ok` the cycle after):
  - C0: IDLE with `fetch_en`.
  - C1: `inst_req`=1.
  - C2: `data_ok`.
  - C3: `inst_valid`=1 and `fetch_ready`=1.
  - C4: IDLE sees the new `fetch_pc`.
  - Sustained throughput is 1 instruction per 4 cycles.
- Each bus wait cycle on `addr_ok` or `data_ok` adds one cycle.
- Misaligned fetch: `inst_valid` is asserted 1 cycle after IDLE.
- `fetch_ready` is purely combinational from state, `de_stall` and `flush`. There is no combinational path from bus inputs.

## Test plan
- Reset release, `fetch_en`=1, `fetch_pc`=0xbfc00000, zero-wait bus returning 0x3c1d8000:
  - `inst_req` in C1 with `inst_addr`=0x1fc00000.
  - `inst_valid` in C3 with `inst`=0x3c1d8000, `inst_pc`=0xbfc00000.
  - `fetch_ready` pulses in C3.
- Bus inserts 2 wait cycles on `addr_ok` and 3 on `data_ok`:
  - `inst_req` and `inst_addr` stay stable throughout.
  - `inst_valid` arrives 5 cycles later than the zero-wait case.
- `de_stall`=1 for 4 cycles while in HOLD:
  - `inst_valid`/`inst` stay stable, `fetch_ready`=0.
  - `fetch_ready` pulses in the first cycle with `de_stall`=0.
- `flush` asserted in RESP before `data_ok`:
  - `fetch_ready`=1 in the flush cycle.
  - The returned word is never presented and `inst_valid` stays 0.
  - The next fetch of 0x80000100 issues `inst_addr`=0x00000100.
- `fetch_pc`=0xbfc00002:
  - No `inst_req`.
  - `inst_valid`=1 with `inst_adel`=1, `inst`=0.
- `rst` asserted in REQ, then released:
  - All outputs are at reset values the cycle after `rst`.
  - A new fetch proceeds normally.

Source files
------------

// File: rtl/ifetch_bridge.sv
// Instruction-fetch bridge: PC stage to SRAM-like instruction bus.
// One transaction in flight, one-entry output buffer toward decode.
module ifetch_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_ready,
    input  logic              flush,
    input  logic              de_stall,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_adel,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              cancel_q, cancel_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic              adel_q, adel_d;
    logic [ADDR_W-1:0] phys_addr;
    logic              misaligned;

    // kseg0/kseg1 fold onto the low 512 MB of physical space.
    always_comb begin
        phys_addr = fetch_pc;
        if (fetch_pc[ADDR_W-1 -: 2] == 2'b10) begin
            phys_addr = {3'b000, fetch_pc[ADDR_W-4:0]};
        end
    end

    assign misaligned = (fetch_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cancel_q <= 1'b0;
            pc_q     <= '0;
            addr_q   <= '0;
            inst_q   <= '0;
            adel_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            inst_q   <= inst_d;
            adel_q   <= adel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        inst_d   = inst_q;
        adel_d   = adel_q;
        unique case (state_q)
            IDLE: begin
                if (fetch_en) begin
                    pc_d = fetch_pc;
                    if (misaligned) begin
                        inst_d  = '0;
                        adel_d  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        addr_d  = phys_addr;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // The bus must see the request through; a flush only marks it dead.
                if (flush) begin
                    cancel_d = 1'b1;
                end
                if (inst_addr_ok) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (inst_data_ok) begin
                    if (cancel_q || flush) begin
                        cancel_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        inst_d  = inst_rdata;
                        adel_d  = 1'b0;
                        state_d = HOLD;
                    end
                end else if (flush) begin
                    cancel_d = 1'b1;
                end
            end
            HOLD: begin
                if (flush || !de_stall) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fetch_ready = ((state_q == HOLD) && !de_stall) || flush;
    assign inst_valid  = (state_q == HOLD);
    assign inst_req    = (state_q == REQ);
    assign inst_addr   = addr_q;
    assign inst        = inst_q;
    assign inst_pc     = pc_q;
    assign inst_adel   = adel_q;

endmodule

// File: tb/tb_ifetch_bridge.sv
// Directed-vector bench for ifetch_bridge.
// Inputs change on the falling edge; outputs are compared 1 ns later.
module tb_ifetch_bridge;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        flush;
    logic        de_stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_adel;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    int errors = 0;
    int checks = 0;

    ifetch_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_en     (fetch_en),
        .fetch_pc     (fetch_pc),
        .fetch_ready  (fetch_ready),
        .flush        (flush),
        .de_stall     (de_stall),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_adel    (inst_adel),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fe;
        logic [31:0] pc;
        logic        fl;
        logic        ds;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
        logic        e_rdy;
        logic        e_val;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_adel;
    } vec_t;

    localparam int NV = 43;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic fe, input logic [31:0] pc, input logic fl,
        input logic ds, input logic aok, input logic dok,
        input logic [31:0] rd, input logic rdy, input logic val,
        input logic req, input logic [31:0] addr,
        input logic [31:0] ins, input logic [31:0] ipc,
        input logic adel);
        vec_t v;
        v.fe = fe; v.pc = pc; v.fl = fl; v.ds = ds;
        v.aok = aok; v.dok = dok; v.rd = rd;
        v.e_rdy = rdy; v.e_val = val; v.e_req = req;
        v.e_addr = addr; v.e_inst = ins; v.e_pc = ipc;
        v.e_adel = adel;
        return v;
    endfunction

    function automatic logic [99:0] outs();
        return {fetch_ready, inst_valid, inst_req, inst_addr,
                inst, inst_pc, inst_adel};
    endfunction

    task automatic check(input string name, input logic [99:0] exp);
        logic [99:0] act;
        act = outs();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got rdy/val/req/addr/inst/pc/adel=%h, want %h",
                     name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        fetch_en     = v.fe;
        fetch_pc     = v.pc;
        flush        = v.fl;
        de_stall     = v.ds;
        inst_addr_ok = v.aok;
        inst_data_ok = v.dok;
        inst_rdata   = v.rd;
    endtask

    initial begin
        // fe pc fl ds aok dok rd | rdy val req addr inst pc adel
        tbl[0]  = mk(1, 32'hbfc00000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
        tbl[1]  = mk(1, 32'hbfc00000, 0, 0, 1, 0, 0, 0, 0, 1, 32'h1fc00000, 32'h0, 32'hbfc00000, 0);
        tbl[2]  = mk(1, 32'hbfc00000, 0, 0, 0, 1, 32'h3c1d8000, 0, 0, 0, 32'h1fc00000, 32'h0, 32'hbfc00000, 0);
        tbl[3]  = mk(1, 32'hbfc00000, 0, 0, 0, 0, 0, 1, 1, 0, 32'h1fc00000, 32'h3c1d8000, 32'hbfc00000, 0);
        tbl[4]  = mk(1, 32'hbfc00004, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1fc00000, 32'h3c1d8000, 32'hbfc00000, 0);
        tbl[5]  = mk(1, 32'hbfc00004, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1fc00004, 32'h3c1d8000, 32'hbfc00004, 0);
        tbl[6]  = mk(1, 32'hbfc00004, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1fc00004, 32'h3c1d8000, 32'hbfc00004, 0);
        tbl[7]  = mk(1, 32'hbfc00004, 0, 0, 1, 0, 0, 0, 0, 1, 32'h1fc00004, 32'h3c1d8000, 32'hbfc00004, 0);
        tbl[8]  = mk(1, 32'hbfc00004, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1fc00004, 32'h3c1d8000, 32'hbfc00004, 0);
        tbl[9]  = mk(1, 32'hbfc00004, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1fc00004, 32'h3c1d8000, 32'hbfc00004, 0);
        tbl[10] = mk(1, 32'hbfc00004, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1fc00004, 32'h3c1d8000, 32'hbfc00004, 0);
        tbl[11] = mk(1, 32'hbfc00004, 0, 0, 0, 1, 32'h24080001, 0, 0, 0, 32'h1fc00004, 32'h3c1d8000, 32'hbfc00004, 0);
        tbl[12] = mk(1, 32'hbfc00004, 0, 1, 0, 0, 0, 0, 1, 0, 32'h1fc00004, 32'h24080001, 32'hbfc00004, 0);
        tbl[13] = mk(1, 32'hbfc00004, 0, 1, 0, 1, 32'hdeadbeef, 0, 1, 0, 32'h1fc00004, 32'h24080001, 32'hbfc00004, 0);
        tbl[14] = mk(1, 32'hbfc00004, 0, 1, 0, 0, 0, 0, 1, 0, 32'h1fc00004, 32'h24080001, 32'hbfc00004, 0);
        tbl[15] = mk(1, 32'hbfc00004, 0, 1, 0, 0, 0, 0, 1, 0, 32'h1fc00004, 32'h24080001, 32'hbfc00004, 0);
        tbl[16] = mk(1, 32'hbfc00004, 0, 0, 0, 0, 0, 1, 1, 0, 32'h1fc00004, 32'h24080001, 32'hbfc00004, 0);
        tbl[17] = mk(1, 32'h80000040, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1fc00004, 32'h24080001, 32'hbfc00004, 0);
        tbl[18] = mk(1, 32'h80000040, 0, 0, 1, 0, 0, 0, 0, 1, 32'h00000040, 32'h24080001, 32'h80000040, 0);
        tbl[19] = mk(1, 32'h80000040, 1, 0, 0, 0, 0, 1, 0, 0, 32'h00000040, 32'h24080001, 32'h80000040, 0);
        tbl[20] = mk(1, 32'h80000040, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000040, 32'h24080001, 32'h80000040, 0);
        tbl[21] = mk(1, 32'h80000040, 0, 0, 0, 1, 32'h11111111, 0, 0, 0, 32'h00000040, 32'h24080001, 32'h80000040, 0);
        tbl[22] = mk(0, 32'h80000040, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000040, 32'h24080001, 32'h80000040, 0);
        tbl[23] = mk(1, 32'h80000100, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000040, 32'h24080001, 32'h80000040, 0);
        tbl[24] = mk(1, 32'h80000100, 0, 0, 1, 0, 0, 0, 0, 1, 32'h00000100, 32'h24080001, 32'h80000100, 0);
        tbl[25] = mk(1, 32'h80000100, 0, 0, 0, 1, 32'h8c020000, 0, 0, 0, 32'h00000100, 32'h24080001, 32'h80000100, 0);
        tbl[26] = mk(1, 32'h80000100, 0, 0, 0, 0, 0, 1, 1, 0, 32'h00000100, 32'h8c020000, 32'h80000100, 0);
        tbl[27] = mk(1, 32'hbfc00002, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000100, 32'h8c020000, 32'h80000100, 0);
        tbl[28] = mk(0, 32'hbfc00002, 0, 0, 0, 0, 0, 1, 1, 0, 32'h00000100, 32'h0, 32'hbfc00002, 1);
        tbl[29] = mk(1, 32'h00400000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000100, 32'h0, 32'hbfc00002, 1);
        tbl[30] = mk(1, 32'h00400000, 0, 0, 1, 0, 0, 0, 0, 1, 32'h00400000, 32'h0, 32'h00400000, 1);
        tbl[31] = mk(1, 32'h00400000, 0, 0, 0, 1, 32'haaaa5555, 0, 0, 0, 32'h00400000, 32'h0, 32'h00400000, 1);
        tbl[32] = mk(1, 32'h00400000, 1, 1, 0, 0, 0, 1, 1, 0, 32'h00400000, 32'haaaa5555, 32'h00400000, 0);
        tbl[33] = mk(0, 32'h00400000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00400000, 32'haaaa5555, 32'h00400000, 0);
        tbl[34] = mk(1, 32'ha0000200, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00400000, 32'haaaa5555, 32'h00400000, 0);
        tbl[35] = mk(1, 32'ha0000200, 0, 0, 1, 0, 0, 0, 0, 1, 32'h00000200, 32'haaaa5555, 32'ha0000200, 0);
        tbl[36] = mk(1, 32'ha0000200, 1, 0, 0, 1, 32'h12345678, 1, 0, 0, 32'h00000200, 32'haaaa5555, 32'ha0000200, 0);
        tbl[37] = mk(0, 32'ha0000200, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000200, 32'haaaa5555, 32'ha0000200, 0);
        tbl[38] = mk(1, 32'h00000300, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000200, 32'haaaa5555, 32'ha0000200, 0);
        tbl[39] = mk(1, 32'h00000300, 1, 0, 0, 0, 0, 1, 0, 1, 32'h00000300, 32'haaaa5555, 32'h00000300, 0);
        tbl[40] = mk(1, 32'h00000300, 0, 0, 1, 0, 0, 0, 0, 1, 32'h00000300, 32'haaaa5555, 32'h00000300, 0);
        tbl[41] = mk(1, 32'h00000300, 0, 0, 0, 1, 32'hffff0000, 0, 0, 0, 32'h00000300, 32'haaaa5555, 32'h00000300, 0);
        tbl[42] = mk(0, 32'h00000300, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000300, 32'haaaa5555, 32'h00000300, 0);

        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check("reset_state", {3'b000, 32'h0, 32'h0, 32'h0, 1'b0});
        flush = 1'b1;
        #1 check("reset_flush_ready", {3'b100, 32'h0, 32'h0, 32'h0, 1'b0});
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            #1 check($sformatf("vec%0d", i),
                     {tbl[i].e_rdy, tbl[i].e_val, tbl[i].e_req,
                      tbl[i].e_addr, tbl[i].e_inst, tbl[i].e_pc,
                      tbl[i].e_adel});
            @(negedge clk);
        end

        // Reset while a request is outstanding, then a clean fetch.
        drive(mk(1, 32'hbfc00010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        #1 check("rst_mid_req_before",
                 {3'b001, 32'h1fc00010, 32'haaaa5555, 32'hbfc00010, 1'b0});
        rst = 1'b1;
        fetch_en = 1'b0;
        @(negedge clk);
        #1 check("rst_mid_req_after", {3'b000, 32'h0, 32'h0, 32'h0, 1'b0});
        rst = 1'b0;
        fetch_en = 1'b1;
        fetch_pc = 32'hbfc00020;
        @(negedge clk);
        fetch_en = 1'b0;
        inst_addr_ok = 1'b1;
        #1 check("post_rst_req", {3'b001, 32'h1fc00020, 32'h0, 32'hbfc00020, 1'b0});
        @(negedge clk);
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata = 32'h0badf00d;
        @(negedge clk);
        inst_data_ok = 1'b0;
        #1 check("post_rst_hold",
                 {3'b110, 32'h1fc00020, 32'h0badf00d, 32'hbfc00020, 1'b0});
        @(negedge clk);
        #1 check("post_rst_idle",
                 {3'b000, 32'h1fc00020, 32'h0badf00d, 32'hbfc00020, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
